// File: rtl/regfile_ctrl_if.sv
// Decoder issue, ROB commit and register-file write bundle for the rename controller.
// master = surrounding pipeline/regfile side, slave = regfile_ctrl.
interface regfile_ctrl_if #(
    parameter int unsigned REG_WIDTH    = 5,
    parameter int unsigned ROB_ID_WIDTH = 4,
    parameter int unsigned VAL_WIDTH    = 32
);
    localparam int unsigned TAG_WIDTH = ROB_ID_WIDTH + 1;

    logic                 dec_issue_valid;
    logic [REG_WIDTH-1:0] dec_issue_rd;
    logic [TAG_WIDTH-1:0] dec_issue_tag;
    logic                 dec_issue_ready;

    logic                 rob_commit_valid;
    logic [REG_WIDTH-1:0] rob_commit_rd;
    logic [TAG_WIDTH-1:0] rob_commit_tag;
    logic [VAL_WIDTH-1:0] rob_commit_res;

    logic [TAG_WIDTH-1:0] rf_lab_cur;

    logic                 rf_val_we;
    logic [REG_WIDTH-1:0] rf_val_addr;
    logic [VAL_WIDTH-1:0] rf_val_data;
    logic                 rf_lab_set_we;
    logic [REG_WIDTH-1:0] rf_lab_set_addr;
    logic [TAG_WIDTH-1:0] rf_lab_set_data;
    logic                 rf_lab_clr_we;
    logic [REG_WIDTH-1:0] rf_lab_clr_addr;

    modport master (
        output dec_issue_valid, dec_issue_rd, dec_issue_tag,
        input  dec_issue_ready,
        output rob_commit_valid, rob_commit_rd, rob_commit_tag, rob_commit_res,
        output rf_lab_cur,
        input  rf_val_we, rf_val_addr, rf_val_data,
        input  rf_lab_set_we, rf_lab_set_addr, rf_lab_set_data,
        input  rf_lab_clr_we, rf_lab_clr_addr
    );

    modport slave (
        input  dec_issue_valid, dec_issue_rd, dec_issue_tag,
        output dec_issue_ready,
        input  rob_commit_valid, rob_commit_rd, rob_commit_tag, rob_commit_res,
        input  rf_lab_cur,
        output rf_val_we, rf_val_addr, rf_val_data,
        output rf_lab_set_we, rf_lab_set_addr, rf_lab_set_data,
        output rf_lab_clr_we, rf_lab_clr_addr
    );
endinterface

// File: rtl/regfile_ctrl.sv
// Rename register-file write controller: merges issue label sets, commit value writes /
// label clears and the reset/flush clear sweeps onto registered regfile write strobes.
module regfile_ctrl #(
    parameter int unsigned REG_WIDTH    = 5,
    parameter int unsigned REG_SIZE     = 32,
    parameter int unsigned ROB_ID_WIDTH = 4,
    parameter int unsigned VAL_WIDTH    = 32
) (
    input  logic          clk,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          flush_in,
    regfile_ctrl_if.slave bus,
    output logic          busy
);
    localparam int unsigned          TAG_WIDTH = ROB_ID_WIDTH + 1;
    localparam logic [REG_WIDTH-1:0] LAST_IDX  = REG_WIDTH'(REG_SIZE - 1);

    typedef enum logic [1:0] {
        RST_SWEEP   = 2'd0,
        IDLE        = 2'd1,
        FLUSH_SWEEP = 2'd2
    } state_e;

    state_e               state, state_d;
    logic [REG_WIDTH-1:0] cnt, cnt_d;

    logic                 val_we_d;
    logic [REG_WIDTH-1:0] val_addr_d;
    logic [VAL_WIDTH-1:0] val_data_d;
    logic                 set_we_d;
    logic [REG_WIDTH-1:0] set_addr_d;
    logic [TAG_WIDTH-1:0] set_data_d;
    logic                 clr_we_d;
    logic [REG_WIDTH-1:0] clr_addr_d;
    logic                 ready_d;
    logic                 busy_d;

    logic                 issue_acc;
    logic                 same_rd;
    logic [TAG_WIDTH-1:0] eff_lab;

    // Next state, sweep counter and next values of every registered strobe.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        val_we_d   = 1'b0;
        val_addr_d = '0;
        val_data_d = '0;
        set_we_d   = 1'b0;
        set_addr_d = '0;
        set_data_d = '0;
        clr_we_d   = 1'b0;
        clr_addr_d = '0;
        issue_acc  = 1'b0;
        same_rd    = 1'b0;

        // A label set still sitting on the output register has not reached the regfile yet.
        eff_lab = bus.rf_lab_cur;
        if (bus.rf_lab_set_we && (bus.rf_lab_set_addr == bus.rob_commit_rd)) begin
            eff_lab = bus.rf_lab_set_data;
        end

        if (rdy_in) begin
            issue_acc = bus.dec_issue_valid && bus.dec_issue_ready && (state == IDLE);
            same_rd   = issue_acc && (bus.dec_issue_rd == bus.rob_commit_rd);

            case (state)
                RST_SWEEP: begin
                    val_we_d   = 1'b1;
                    val_addr_d = cnt;
                    clr_we_d   = 1'b1;
                    clr_addr_d = cnt;
                    if (cnt == LAST_IDX) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + REG_WIDTH'(1);
                    end
                end
                IDLE: begin
                    if (flush_in) begin
                        state_d = FLUSH_SWEEP;
                        cnt_d   = '0;
                    end
                end
                FLUSH_SWEEP: begin
                    if (flush_in) begin
                        cnt_d = '0;
                    end else begin
                        clr_we_d   = 1'b1;
                        clr_addr_d = cnt;
                        if (cnt == LAST_IDX) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt + REG_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = RST_SWEEP;
                    cnt_d   = '0;
                end
            endcase

            // Commits write values outside the reset sweep; the clear port belongs to sweeps.
            if ((state != RST_SWEEP) && bus.rob_commit_valid && (bus.rob_commit_rd != '0)) begin
                val_we_d   = 1'b1;
                val_addr_d = bus.rob_commit_rd;
                val_data_d = bus.rob_commit_res;
                if ((state == IDLE) && !flush_in && (eff_lab == bus.rob_commit_tag) && !same_rd) begin
                    clr_we_d   = 1'b1;
                    clr_addr_d = bus.rob_commit_rd;
                end
            end

            if (issue_acc && (bus.dec_issue_rd != '0)) begin
                set_we_d   = 1'b1;
                set_addr_d = bus.dec_issue_rd;
                set_data_d = bus.dec_issue_tag;
            end
        end

        ready_d = rdy_in && (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state               <= RST_SWEEP;
            cnt                 <= '0;
            bus.rf_val_we       <= 1'b0;
            bus.rf_val_addr     <= '0;
            bus.rf_val_data     <= '0;
            bus.rf_lab_set_we   <= 1'b0;
            bus.rf_lab_set_addr <= '0;
            bus.rf_lab_set_data <= '0;
            bus.rf_lab_clr_we   <= 1'b0;
            bus.rf_lab_clr_addr <= '0;
            bus.dec_issue_ready <= 1'b0;
            busy                <= 1'b1;
        end else begin
            state               <= state_d;
            cnt                 <= cnt_d;
            bus.rf_val_we       <= val_we_d;
            bus.rf_val_addr     <= val_addr_d;
            bus.rf_val_data     <= val_data_d;
            bus.rf_lab_set_we   <= set_we_d;
            bus.rf_lab_set_addr <= set_addr_d;
            bus.rf_lab_set_data <= set_data_d;
            bus.rf_lab_clr_we   <= clr_we_d;
            bus.rf_lab_clr_addr <= clr_addr_d;
            bus.dec_issue_ready <= ready_d;
            busy                <= busy_d;
        end
    end
endmodule
